// File: rtl/mips32_prog_loader_if.sv
// Byte-serial load stream feeding the program loader.
// Source drives valid/data; loader answers with ready.
interface mips32_prog_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/mips32_prog_loader.sv
// Boot loader: byte frame -> Mem words, then releases the core.
// Frame: SYNC, base(2), count(2), words(4 each), xor checksum.
module mips32_prog_loader #(
  parameter int         ADDR_W    = 10,
  parameter int         MEM_DEPTH = 1024,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                  clk1,
  input  logic                  rst,
  mips32_prog_loader_if.slave   in_if,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_halt,
  output logic                  cpu_start,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CNT,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] base_q;
  logic [15:0] cnt_q;
  logic [15:0] idx_q;
  logic [23:0] word_q;
  logic [7:0]  xsum_q;
  logic [1:0]  bcnt_q;

  logic        acc;
  logic        hdr_last;
  logic        word_last;
  logic        frame_last;
  logic        csum_ok;
  logic [15:0] base_full;
  logic [15:0] cnt_full;
  logic [16:0] end_addr;

  assign acc        = in_if.in_valid & in_if.in_ready;
  assign hdr_last   = bcnt_q[0];
  assign word_last  = (bcnt_q == 2'd3);
  assign frame_last = (idx_q == cnt_q - 16'd1);
  assign csum_ok    = (in_if.in_data == xsum_q);
  assign base_full  = {base_q[7:0], in_if.in_data};
  assign cnt_full   = {cnt_q[7:0], in_if.in_data};
  // 17 bits so base+N cannot wrap before the range check
  assign end_addr   = {1'b0, base_q} + {1'b0, cnt_full};

  assign in_if.in_ready = (state_q != S_DONE) &&
                          (state_q != S_ERR);
  assign cpu_halt = (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign busy     = (state_q == S_ADDR) ||
                    (state_q == S_CNT)  ||
                    (state_q == S_DATA) ||
                    (state_q == S_CSUM);

  always_ff @(posedge clk1) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc && in_if.in_data == SYNC_BYTE)
          state_d = S_ADDR;
      end
      S_ADDR: begin
        if (acc && hdr_last)
          state_d = (|(base_full >> ADDR_W)) ?
                    S_ERR : S_CNT;
      end
      S_CNT: begin
        if (acc && hdr_last) begin
          if (end_addr > 17'(MEM_DEPTH))
            state_d = S_ERR;
          else if (cnt_full == 16'd0)
            state_d = S_CSUM;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (acc && word_last && frame_last)
          state_d = S_CSUM;
      end
      S_CSUM: begin
        if (acc)
          state_d = csum_ok ? S_DONE : S_ERR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      base_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      xsum_q    <= '0;
      bcnt_q    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_start <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      cpu_start <= 1'b0;
      if (acc) begin
        unique case (state_q)
          S_IDLE: begin
            xsum_q <= '0;
            bcnt_q <= '0;
          end
          S_ADDR: begin
            base_q <= base_full;
            xsum_q <= xsum_q ^ in_if.in_data;
            bcnt_q <= {1'b0, ~bcnt_q[0]};
          end
          S_CNT: begin
            cnt_q  <= cnt_full;
            xsum_q <= xsum_q ^ in_if.in_data;
            bcnt_q <= {1'b0, ~bcnt_q[0]};
            idx_q  <= '0;
          end
          S_DATA: begin
            word_q <= {word_q[15:0], in_if.in_data};
            xsum_q <= xsum_q ^ in_if.in_data;
            bcnt_q <= bcnt_q + 2'd1;
            if (word_last) begin
              mem_we    <= 1'b1;
              mem_addr  <= base_q[ADDR_W-1:0] +
                           idx_q[ADDR_W-1:0];
              mem_wdata <= {word_q, in_if.in_data};
              idx_q     <= idx_q + 16'd1;
            end
          end
          S_CSUM: cpu_start <= csum_ok;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/mips32_prog_loader.md
Name: mips32_prog_loader

Overview:
Boot-time program loader that sits directly upstream of the pipe_MIPS32 core.
- Receives a byte-serial load frame (valid/ready), assembles big-endian 32-bit words and writes them into the core's unified Mem array.
- Holds the core halted during the load, then releases it with a one-cycle start pulse once the frame checksum verifies.
- Replaces hand-poking Mem/PC/HALTED from the bench.

Parameters:
ADDR_W, 10, width of the memory word address.
MEM_DEPTH, 1024, number of 32-bit words in Mem; the highest legal address is MEM_DEPTH-1.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
clk1  input  1  clock; driven from the core's clk1 phase.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_data holds a byte.
in_data  input  8  serial frame byte.
in_ready  output  1  loader can accept a byte.
mem_we  output  1  write strobe into Mem.
mem_addr  output  ADDR_W  word address for the write.
mem_wdata  output  32  word to write.
cpu_halt  output  1  holds the core halted; drives HALTED and forces PC=0.
cpu_start  output  1  one-cycle pulse: clear TAKEN_BRANCH, begin fetch at PC=0.
busy  output  1  a frame is in progress (any state after SYNC).
done  output  1  sticky: load completed and checksum matched.
err  output  1  sticky: frame rejected.

Behaviour:
- Byte transfer occurs on a rising clk1 edge with in_valid & in_ready.
- in_ready = 1 in IDLE, ADDR, CNT, DATA and CSUM; 0 in DONE and ERR.
- Frame format: SYNC_BYTE, base address (2 bytes, MSB first), word count N (2 bytes, MSB first), N×4 data bytes (each word MSB first), checksum byte.
- Checksum = XOR of every byte after SYNC, excluding the checksum byte itself.
- States: IDLE -> ADDR -> CNT -> DATA -> CSUM -> DONE | ERR.
- IDLE: bytes other than SYNC_BYTE are accepted and discarded. SYNC_BYTE -> ADDR, clear the running XOR.
- ADDR: 2 bytes form base. Upper bits beyond ADDR_W must be zero, else -> ERR.
- CNT: 2 bytes form N. If base+N > MEM_DEPTH (17-bit compare) -> ERR. N=0 -> CSUM directly. Otherwise -> DATA with word index 0 and byte index 0.
- DATA: bytes shift into a 32-bit word register.
  - On the edge accepting byte 3 of a word, the next cycle shows mem_we=1, mem_addr=base+index, mem_wdata=assembled word, for exactly one cycle.
  - index increments; after word N-1 -> CSUM.
  - Back-to-back bytes at full rate are supported; no stall.
- CSUM: byte == running XOR -> DONE; mismatch -> ERR.
  - Words already written are not rolled back.
- DONE: done=1. cpu_halt falls to 0 and cpu_start=1 for exactly one cycle, in the cycle after the checksum byte is accepted. Stays in DONE (ignores input) until rst.
- ERR: err=1, cpu_halt stays 1, cpu_start never pulses. Stays in ERR until rst.
- Reset values: state IDLE; in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_halt=1, cpu_start=0, busy=0, done=0, err=0; XOR, index and byte counters 0.
- Reset mid-frame: abort immediately. Any pending write strobe is dropped (mem_we=0 in the cycle after rst). Return to IDLE awaiting SYNC.
- Mem is never written outside DATA. Addresses never wrap; an overflowing frame is rejected at CNT, before any write.
- in_valid low in any receiving state: hold state; no timeout.

Test Plan:
- Single-word frame A5 00 05 00 01 FC 00 00 00 F8 -> one mem_we pulse with addr=5, wdata=32'hFC000000; then cpu_start pulse, done=1, cpu_halt=0.
- Eight-word frame to base 0 carrying 28010078, 0C631800, 20220000, 0C631800, 2842002C, 0C631800, 24220001, FC000000 with correct XOR -> eight consecutive writes to addr 0..7 with those values; start pulse follows the checksum byte by one cycle.
- Same single-word frame with checksum 0x00 -> write to addr 5 still occurs; err=1, cpu_halt=1, no cpu_start, in_ready=0.
- Frame base 0x03FF, N=2 -> err at CNT, zero mem_we pulses. Frame base 0x03FF, N=1 with correct checksum -> write to addr 1023, done=1.
- Garbage bytes 00 FF 12 before A5, plus random in_valid gaps within the frame -> garbage discarded; same writes and start as the gap-free case.
- rst asserted after 2 of 4 data bytes, then a fresh valid frame -> no write from the aborted frame; the new frame loads normally. N=0 frame A5 00 00 00 00 00 -> no writes, done=1.
